// File: rtl/serial_operand_feeder_if.sv
// Operand handshake and serial bit-pair bus between a producer and serial_operand_feeder.
interface serial_operand_feeder_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_en;
  logic             bit_a;
  logic             bit_b;
  logic             bit_valid;
  logic             first_bit;
  logic             last_bit;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, a, b, out_en,
    input  in_ready, bit_a, bit_b, bit_valid, first_bit, last_bit, busy, done
  );

  modport slave (
    input  in_valid, a, b, out_en,
    output in_ready, bit_a, bit_b, bit_valid, first_bit, last_bit, busy, done
  );
endinterface

// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial feeder: streams two operands LSB-first as framed bit pairs,
// optionally followed by a zero beat that flushes the downstream carry.
module serial_operand_feeder #(
  parameter int WIDTH    = 4,
  parameter int FLUSH_EN = 1
) (
  input logic                   clk,
  input logic                   rst,
  serial_operand_feeder_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             done_r;
  logic             load;
  logic             advance;
  logic             xfer_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    xfer_last = 1'b0;
    case (state)
      IDLE: begin
        load = bus.in_valid;
        if (load) state_nxt = SHIFT;
      end
      SHIFT: begin
        advance = bus.out_en;
        if (bus.out_en && cnt == CNT_LAST) begin
          if (FLUSH_EN != 0) begin
            state_nxt = FLUSH;
          end else begin
            state_nxt = IDLE;
            xfer_last = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (bus.out_en) begin
          state_nxt = IDLE;
          xfer_last = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counter returns to zero on the last shift so it never leaves 0..WIDTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a   <= '0;
      sh_b   <= '0;
      cnt    <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= xfer_last;
      if (load) begin
        sh_a <= bus.a;
        sh_b <= bus.b;
        cnt  <= '0;
      end else if (advance) begin
        sh_a <= {1'b0, sh_a[WIDTH-1:1]};
        sh_b <= {1'b0, sh_b[WIDTH-1:1]};
        cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end
    end
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_a     = 1'b0;
    bus.bit_b     = 1'b0;
    bus.first_bit = 1'b0;
    bus.last_bit  = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = done_r;
    if (!rst) begin
      case (state)
        IDLE: bus.in_ready = 1'b1;
        SHIFT: begin
          bus.bit_valid = 1'b1;
          bus.busy      = 1'b1;
          bus.bit_a     = sh_a[0];
          bus.bit_b     = sh_b[0];
          bus.first_bit = (cnt == '0);
          bus.last_bit  = (FLUSH_EN == 0) && (cnt == CNT_LAST);
        end
        FLUSH: begin
          bus.bit_valid = 1'b1;
          bus.busy      = 1'b1;
          bus.last_bit  = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
